// File: rtl/shift_defs.sv
// Shared op-code and FSM state encodings for the iterative 16-bit shifter.
// Right-hand ops are done by reversing bits, shifting left, then reversing back.
package shift_defs;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic op_is_right(input logic [1:0] op);
    return (op == OP_ROR) || (op == OP_SRL);
  endfunction

  function automatic logic op_is_logical(input logic [1:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

  function automatic logic op_is_rotate(input logic [1:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/reverse_16b.sv
// Conditional 16-bit bit reversal; passes data through unchanged when revBit=0.
module reverse_16b (
  input  logic        revBit,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  logic [15:0] rev;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      rev[i] = din[15-i];
    end
  end

  assign dout = revBit ? rev : din;

endmodule

// File: rtl/shift_iter_16b.sv
// Iterative 16-bit shifter/rotator: one bit position per clock, ROR/SRL via reversal.
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | shifting shreg left once per cycle until count reaches 0
//   DONE  | out holds a new result, done=1 for this cycle; start accepted
module shift_iter_16b
  import shift_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [3:0]  amt,
  input  logic [15:0] in,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] shreg_q, shreg_d;
  logic [15:0] out_q, out_d;
  logic [15:0] in_rev;
  logic [15:0] shreg_rev;

  reverse_16b u_rev_in (
    .revBit (op_is_right(op)),
    .din    (in),
    .dout   (in_rev)
  );

  reverse_16b u_rev_out (
    .revBit (op_is_right(op_q)),
    .din    (shreg_q),
    .dout   (shreg_rev)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    shreg_d = shreg_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          op_d    = op;
          count_d = amt;
          shreg_d = in_rev;
        end
      end
      ST_SHIFT: begin
        if (count_q != 4'd0) begin
          // Rotates wrap bit 15 into bit 0; logical shifts zero-fill.
          shreg_d = {shreg_q[14:0], op_is_logical(op_q) ? 1'b0 : shreg_q[15]};
          count_d = count_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          out_d   = shreg_rev;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_SHIFT;
          op_d    = op;
          count_d = amt;
          shreg_d = in_rev;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      count_q <= 4'd0;
      shreg_q <= 16'h0000;
      out_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
    end
  end

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign out   = out_q;

endmodule

// File: tb/tb_shift_iter_16b.sv
// Self-checking bench for shift_iter_16b: directed cases plus 1000 random ops
// against an arithmetic shift/rotate reference.
module tb_shift_iter_16b;
  import shift_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic [15:0] in;
  logic        ready, busy, done;
  logic [15:0] out;

  int n_chk = 0;
  int n_err = 0;

  shift_iter_16b dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .amt   (amt),
    .in    (in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_shift(input logic [1:0] o, input logic [3:0] a,
                                            input logic [15:0] d);
    int unsigned x, r;
    x = {16'h0, d};
    case (o)
      OP_ROL:  r = (x << a) | (x >> (16 - a));
      OP_SLL:  r = x << a;
      OP_ROR:  r = (x >> a) | (x << (16 - a));
      default: r = x >> a;
    endcase
    return r[15:0];
  endfunction

  // Issue one op, randomly disturb inputs (and pulse start) while busy,
  // then check latency, result, busy duration and single-cycle done.
  task automatic run_op(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d,
                        input string tag);
    int          cyc, nbusy;
    bit          got;
    logic [15:0] expv;
    expv = ref_shift(o, a, d);
    for (int i = 0; i < 50 && !ready; i++) tick();
    chk({tag, "_ready"}, ready, 1);
    start = 1'b1; op = o; amt = a; in = d;
    tick();
    start = 1'b0;
    op = 2'($urandom); amt = 4'($urandom); in = 16'($urandom);
    nbusy = busy;
    cyc = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) start = 1'($urandom);
      tick();
      cyc++;
      nbusy += busy;
      in = 16'($urandom);
      if (done) begin
        got = 1;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_lat"}, got ? cyc : -1, a + 1);
    chk({tag, "_out"}, out, expv);
    chk({tag, "_busy"}, nbusy, a + 1);
    tick();
    chk({tag, "_pulse"}, {done, ready}, 2'b01);
    chk({tag, "_hold"}, out, expv);
  endtask

  int cyc, ndone;
  bit got;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; amt = 4'd0; in = 16'h0;
    tick();
    tick();
    chk("rst_out", out, 16'h0000);
    chk("rst_flags", {done, busy, ready}, 3'b001);
    rst = 1'b0;
    tick();

    run_op(OP_ROL, 4'd1, 16'h8001, "rol1");
    run_op(OP_SLL, 4'd4, 16'h00FF, "sll4");
    run_op(OP_ROR, 4'd15, 16'h0001, "ror15");
    run_op(OP_SRL, 4'd15, 16'h8000, "srl15");
    chk("rol1_lit", ref_shift(OP_ROL, 4'd1, 16'h8001), 16'h0003);
    chk("sll4_lit", ref_shift(OP_SLL, 4'd4, 16'h00FF), 16'h0FF0);
    for (int k = 0; k < 4; k++) run_op(2'(k), 4'd0, 16'hA5C3, "amt0");

    // Start while busy is ignored; then a back-to-back start in DONE.
    start = 1'b1; op = OP_SRL; amt = 4'd8; in = 16'h8000;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; op = OP_SLL; amt = 4'd2; in = 16'hFFFF;
    tick();
    start = 1'b0;
    cyc = 3; got = 0; ndone = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cyc++;
      if (done) begin got = 1; break; end
    end
    chk("ign_lat", got ? cyc : -1, 9);
    chk("ign_out", out, 16'h0080);
    start = 1'b1; op = OP_ROL; amt = 4'd3; in = 16'h1234;
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_keep", out, 16'h0080);
    cyc = 0; got = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cyc++;
      if (done) begin got = 1; break; end
    end
    chk("b2b_lat", got ? cyc : -1, 4);
    chk("b2b_out", out, 16'h91A0);
    tick();
    chk("b2b_pulse", done, 0);

    // Reset in the middle of a SHIFT abandons the op.
    start = 1'b1; op = OP_SLL; amt = 4'd10; in = 16'h00FF;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out", out, 16'h0000);
    chk("mid_rst_flags", {done, busy, ready}, 3'b001);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ndone += done;
    end
    chk("mid_rst_nodone", ndone, 0);
    run_op(OP_ROR, 4'd3, 16'h000F, "post_rst");

    for (int n = 0; n < 1000; n++)
      run_op(2'($urandom), 4'($urandom), 16'($urandom), "rnd");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
